guess_input: RTL and testbench
==============================

# guess_input

Front-end input stage for the Bulls & Cows game core. Synchronises and debounces the raw confirm button and captures the 16-bit switch word (four BCD digits) once per debounced press. Checks the word against the game rules: every digit 0–9 and all digits distinct. Presents a legal word to the downstream game FSM over a valid/ready handshake; rejects an illegal word with a one-cycle error pulse and a reason code.

## Interface
- `DEBOUNCE_CYCLES`, default 500000: consecutive synchronised cycles the button must be stable, for both press and release; legal range ≥ 2.
- `clock` in 1: single system clock; all logic on its rising edge.
- `reset` in 1: synchronous, active-high.
- `guess_sw` in 16: raw switches.
  - Digit 3 = [15:12] (most significant), digit 0 = [3:0].
  - Static during a press; no synchroniser required.
- `confirm_btn` in 1: raw asynchronous push button, active-high.
- `guess` out 16: captured word; stable whenever `guess_valid` = 1.
- `guess_valid` out 1: legal word available; held until accepted.
- `guess_ready` in 1: downstream accepts `guess` in any cycle where `guess_valid` & `guess_ready`.
- `guess_error` out 1: one-cycle pulse, captured word rejected.
- `error_code` out 2: reason for the last rejection.
  - 00 none; 01 digit > 9; 10 repeated digit.
  - Held until the next capture.

## Operation
- `confirm_btn` passes through a 2-flop synchroniser, giving `c_s`; the flops reset to 0.
- FSM states: IDLE, PRESS, CHECK, HOLD, RELEASE. Shared counter `cnt` is sized by $clog2(DEBOUNCE_CYCLES+1).
- IDLE:
  - `c_s` = 1 → PRESS, `cnt` ← 1.
- PRESS:
  - `c_s` = 0 → IDLE (bounce rejected, nothing captured).
  - Otherwise, if `cnt` = DEBOUNCE_CYCLES−1 → capture `guess_sw` into `guess`, `error_code` ← 00, → CHECK.
  - Otherwise `cnt` increments.
- CHECK (exactly one cycle), evaluated on the captured word:
  - Any digit > 9 → `error_code` 01.
  - Else any pair of the 6 digit pairs equal → `error_code` 10. Digit range has priority over repeats.
  - Legal word → HOLD with `guess_valid` ← 1.
  - Illegal word → `guess_error` ← 1 for one cycle, → RELEASE.
- HOLD:
  - `guess_valid` = 1, `guess` frozen.
  - `guess_ready` = 1 → `guess_valid` ← 0, → RELEASE, `cnt` ← 0.
  - No timeout.
- RELEASE:
  - `c_s` = 0 → `cnt` increments; `c_s` = 1 → `cnt` ← 0.
  - Reaching DEBOUNCE_CYCLES → IDLE.
  - A button held through HOLD therefore never produces a second capture.
- Presses outside IDLE are ignored; there is no queue.

## Timing
- Reset values:
  - State RELEASE, `cnt` 0.
  - `guess` 0x0000, `guess_valid` 0, `guess_error` 0, `error_code` 00.
  - Consequence: a button held across reset must first be released and debounced.
- Reset asserted in any state, including mid-PRESS and mid-HOLD: every output takes its reset value at the next edge, and any pending word is discarded.
- Latency, counting edge 0 as the first edge sampling `confirm_btn` = 1 with the button held:
  - `c_s` = 1 after edge 1.
  - PRESS entered at edge 2; capture at edge DEBOUNCE_CYCLES+1.
  - `guess_valid` or `guess_error` registers high at edge DEBOUNCE_CYCLES+2.
- `guess_valid` & `guess_ready` in the same cycle is a transfer; `guess_valid` is low at the following edge.
- `guess_ready` asserted before `guess_valid` has no effect. The earliest possible transfer is the first cycle of HOLD.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Structure
- Shared package `bulls_cows_pkg` holds:
  - the state typedef `input_state_t`;
  - the error-code enum `guess_err_t` (ERR_NONE, ERR_RANGE, ERR_REPEAT);
  - `NUM_DIGITS` = 4 and `DIGIT_W` = 4, reused by the game core.
- One sub-module, `sync_2ff`: a parameterless 1-bit 2-flop synchroniser with synchronous reset, reusable for later button inputs.
- The rule check is a combinational function in the package, `guess_check(word) → guess_err_t`. The game core reuses it to validate secrets.

## Test plan
All scenarios use DEBOUNCE_CYCLES = 4.
- Legal word: hold `guess_sw` = 0x1234, raise `confirm_btn` and hold it.
  - `guess_valid` high at edge 6, `guess` = 0x1234.
  - `guess_ready` low for 10 cycles → `guess_valid` stays high.
  - Pulse `guess_ready` → `guess_valid` low at the next edge.
- Range error: `guess_sw` = 0x1A23 with a press → `guess_error` one-cycle pulse at edge 6, `error_code` = 01, `guess_valid` never high.
- Repeat and priority:
  - 0x1231 → `error_code` 10.
  - 0xAA12 → `error_code` 01 (range wins).
  - A following legal press clears `error_code` to 00.
- Bounce:
  - `confirm_btn` high for 2 cycles, low for 1, high for 2, then low → no output.
  - A press held through HOLD and accept, with `guess_sw` changed to 0x5678 → no second capture until the button has been low for 4 cycles.
- Reset:
  - Reset asserted in HOLD → `guess_valid` 0 at the next edge.
  - `confirm_btn` held through and after reset → no capture.
  - Release for 4 cycles, then press → normal capture.

Source files
------------

// File: rtl/bulls_cows_pkg.sv
// Shared types and the digit-rule check for the Bulls & Cows design.
// Contents:
//   input_state_t - guess_input FSM states
//   guess_err_t   - rejection reason codes
//   NUM_DIGITS, DIGIT_W, GUESS_W - word geometry
//   guess_check() - classifies a four-digit BCD word
package bulls_cows_pkg;

    localparam int unsigned NUM_DIGITS = 4;
    localparam int unsigned DIGIT_W    = 4;
    localparam int unsigned GUESS_W    = NUM_DIGITS * DIGIT_W;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_PRESS   = 3'd1,
        ST_CHECK   = 3'd2,
        ST_HOLD    = 3'd3,
        ST_RELEASE = 3'd4
    } input_state_t;

    typedef enum logic [1:0] {
        ERR_NONE   = 2'b00,
        ERR_RANGE  = 2'b01,
        ERR_REPEAT = 2'b10
    } guess_err_t;

    // Digit range takes priority over repeated digits.
    function automatic guess_err_t guess_check(input logic [GUESS_W-1:0] word);
        logic             range_bad;
        logic             repeat_bad;
        logic [DIGIT_W-1:0] di;
        logic [DIGIT_W-1:0] dj;
        range_bad  = 1'b0;
        repeat_bad = 1'b0;
        for (int i = 0; i < int'(NUM_DIGITS); i++) begin
            di = word[i*DIGIT_W +: DIGIT_W];
            if (di > DIGIT_W'(9)) begin
                range_bad = 1'b1;
            end
            for (int j = i + 1; j < int'(NUM_DIGITS); j++) begin
                dj = word[j*DIGIT_W +: DIGIT_W];
                if (di == dj) begin
                    repeat_bad = 1'b1;
                end
            end
        end
        if (range_bad) begin
            return ERR_RANGE;
        end else if (repeat_bad) begin
            return ERR_REPEAT;
        end
        return ERR_NONE;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// 1-bit two-flop synchroniser with synchronous active-high reset.
// Ports:
//   clock, reset - system clock / sync reset (flops clear to 0)
//   d            - asynchronous input
//   q            - synchronised output (two cycles of latency)
module sync_2ff (
    input  logic clock,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic meta_q, meta_d;
    logic sync_q, sync_d;

    always_comb begin
        meta_d = d;
        sync_d = meta_q;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/guess_input.sv
// Bulls & Cows input stage: debounces the confirm button, captures the
// switch word once per press, checks it and hands legal words downstream.
// Ports:
//   clock, reset   - system clock, synchronous active-high reset
//   guess_sw       - raw switch word, four BCD digits (digit 3 in [15:12])
//   confirm_btn    - raw asynchronous confirm button
//   guess          - captured word, stable while guess_valid
//   guess_valid    - legal word available, held until accepted
//   guess_ready    - downstream accept
//   guess_error    - one-cycle pulse on a rejected word
//   error_code     - reason for the last rejection, held until next capture
// DEBOUNCE_CYCLES must be >= 2.
module guess_input
    import bulls_cows_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 500000
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [GUESS_W-1:0] guess_sw,
    input  logic               confirm_btn,
    output logic [GUESS_W-1:0] guess,
    output logic               guess_valid,
    input  logic               guess_ready,
    output logic               guess_error,
    output logic [1:0]         error_code
);

    localparam int unsigned      CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic c_s;

    input_state_t       state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [GUESS_W-1:0] guess_q, guess_d;
    logic               guess_valid_q, guess_valid_d;
    logic               guess_error_q, guess_error_d;
    guess_err_t         error_code_q, error_code_d;
    guess_err_t         check_res;

    sync_2ff u_sync_btn (
        .clock (clock),
        .reset (reset),
        .d     (confirm_btn),
        .q     (c_s)
    );

    // Next-state and output logic.
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        guess_d       = guess_q;
        guess_valid_d = guess_valid_q;
        guess_error_d = 1'b0;
        error_code_d  = error_code_q;
        check_res     = guess_check(guess_q);

        case (state_q)
            ST_IDLE: begin
                if (c_s) begin
                    state_d = ST_PRESS;
                    cnt_d   = CNT_W'(1);
                end
            end
            ST_PRESS: begin
                if (!c_s) begin
                    state_d = ST_IDLE;
                end else if (cnt_q == CNT_LAST) begin
                    guess_d      = guess_sw;
                    error_code_d = ERR_NONE;
                    state_d      = ST_CHECK;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_CHECK: begin
                error_code_d = check_res;
                if (check_res == ERR_NONE) begin
                    guess_valid_d = 1'b1;
                    state_d       = ST_HOLD;
                end else begin
                    guess_error_d = 1'b1;
                    cnt_d         = '0;
                    state_d       = ST_RELEASE;
                end
            end
            ST_HOLD: begin
                if (guess_ready) begin
                    guess_valid_d = 1'b0;
                    cnt_d         = '0;
                    state_d       = ST_RELEASE;
                end
            end
            ST_RELEASE: begin
                // Any high sample restarts the release debounce window.
                if (c_s) begin
                    cnt_d = '0;
                end else if (cnt_q == CNT_LAST) begin
                    cnt_d   = '0;
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                cnt_d   = '0;
                state_d = ST_RELEASE;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q       <= ST_RELEASE;
            cnt_q         <= '0;
            guess_q       <= '0;
            guess_valid_q <= 1'b0;
            guess_error_q <= 1'b0;
            error_code_q  <= ERR_NONE;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            guess_q       <= guess_d;
            guess_valid_q <= guess_valid_d;
            guess_error_q <= guess_error_d;
            error_code_q  <= error_code_d;
        end
    end

    assign guess       = guess_q;
    assign guess_valid = guess_valid_q;
    assign guess_error = guess_error_q;
    assign error_code  = error_code_q;

endmodule

// File: tb/tb_guess_input.sv
// Self-checking bench for guess_input with DEBOUNCE_CYCLES = 4.
module tb_guess_input;

    localparam int unsigned D = 4;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] guess_sw = 16'h0000;
    logic        confirm_btn = 1'b0;
    logic        guess_ready = 1'b0;
    logic [15:0] guess;
    logic        guess_valid;
    logic        guess_error;
    logic [1:0]  error_code;

    guess_input #(.DEBOUNCE_CYCLES(D)) dut (
        .clock       (clock),
        .reset       (reset),
        .guess_sw    (guess_sw),
        .confirm_btn (confirm_btn),
        .guess       (guess),
        .guess_valid (guess_valid),
        .guess_ready (guess_ready),
        .guess_error (guess_error),
        .error_code  (error_code)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [15:0] sw;
        logic        legal;
        logic [1:0]  code;
        int          hold;
    } vec_t;

    typedef struct {
        logic [15:0] sw;
        logic        legal;
        logic [1:0]  code;
        int          cyc;
    } exp_t;

    exp_t sb[$];
    vec_t vecs[10];
    int   compared   = 0;
    int   mismatched = 0;
    int   cyc        = 0;
    int   seen       = 0;
    logic prev_valid = 1'b0;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0h expected %0h (cyc %0d)", name, act, exp, cyc);
        end
    endtask

    // Output monitor: every new valid or error pulse is matched against the scoreboard.
    always @(posedge clock) begin
        exp_t e;
        #2;
        if (!reset && ((guess_valid && !prev_valid) || guess_error)) begin
            seen++;
            compared++;
            if (sb.size() == 0) begin
                mismatched++;
                $display("FAIL unexpected_output: valid=%0b error=%0b guess=%h, none expected (cyc %0d)",
                         guess_valid, guess_error, guess, cyc);
            end else begin
                e = sb.pop_front();
                if (guess_valid !== e.legal || guess_error !== !e.legal || guess !== e.sw ||
                    error_code !== e.code || cyc != e.cyc) begin
                    mismatched++;
                    $display("FAIL sb_out: got v=%0b e=%0b guess=%h code=%0d cyc=%0d expected v=%0b e=%0b guess=%h code=%0d cyc=%0d",
                             guess_valid, guess_error, guess, error_code, cyc,
                             e.legal, !e.legal, e.sw, e.code, e.cyc);
                end
            end
        end
        prev_valid = guess_valid;
    end

    task automatic start_press(input logic [15:0] sw, input logic legal, input logic [1:0] code);
        exp_t e;
        @(negedge clock);
        guess_sw    = sw;
        confirm_btn = 1'b1;
        e.sw    = sw;
        e.legal = legal;
        e.code  = legal ? 2'b00 : code;
        e.cyc   = cyc + int'(D) + 3;
        sb.push_back(e);
    endtask

    task automatic wait_output(input int seen0);
        int n;
        n = 0;
        while (seen == seen0 && n < 40) begin
            @(negedge clock);
            n++;
        end
        if (seen == seen0) chk("wait_output_timeout", 32'd0, 32'd1);
    endtask

    // Check hold/accept for a legal word, or the single-cycle pulse for an error.
    task automatic finish_press(input logic [15:0] sw, input logic legal, input logic [1:0] code,
                                input int hold);
        if (legal) begin
            chk("code_cleared", 32'(error_code), 32'd0);
            for (int i = 0; i < hold; i++) begin
                @(negedge clock);
                chk("hold_valid", 32'(guess_valid), 32'd1);
                chk("hold_guess", 32'(guess), 32'(sw));
            end
            guess_ready = 1'b1;
            @(negedge clock);
            guess_ready = 1'b0;
            chk("valid_after_accept", 32'(guess_valid), 32'd0);
        end else begin
            @(negedge clock);
            chk("error_one_cycle", 32'(guess_error), 32'd0);
            chk("error_code_held", 32'(error_code), 32'(code));
            chk("error_no_valid", 32'(guess_valid), 32'd0);
        end
    endtask

    task automatic release_btn();
        confirm_btn = 1'b0;
        repeat (D + 4) @(negedge clock);
    endtask

    initial begin
        int s0;
        vecs[0] = '{16'h1234, 1'b1, 2'b00, 10};
        vecs[1] = '{16'h1A23, 1'b0, 2'b01, 0};
        vecs[2] = '{16'h1231, 1'b0, 2'b10, 0};
        vecs[3] = '{16'hAA12, 1'b0, 2'b01, 0};
        vecs[4] = '{16'h1234, 1'b1, 2'b00, 1};
        vecs[5] = '{16'h0000, 1'b0, 2'b10, 0};
        vecs[6] = '{16'h00F0, 1'b0, 2'b01, 0};
        vecs[7] = '{16'h9870, 1'b1, 2'b00, 2};
        vecs[8] = '{16'h4554, 1'b0, 2'b10, 0};
        vecs[9] = '{16'h9012, 1'b1, 2'b00, 0};

        // Reset state.
        repeat (3) @(negedge clock);
        reset = 1'b0;
        chk("rst_guess", 32'(guess), 32'd0);
        chk("rst_valid", 32'(guess_valid), 32'd0);
        chk("rst_error", 32'(guess_error), 32'd0);
        chk("rst_code", 32'(error_code), 32'd0);
        repeat (D + 4) @(negedge clock);

        // Table-driven presses.
        for (int i = 0; i < 10; i++) begin
            s0 = seen;
            start_press(vecs[i].sw, vecs[i].legal, vecs[i].code);
            wait_output(s0);
            finish_press(vecs[i].sw, vecs[i].legal, vecs[i].code, vecs[i].hold);
            release_btn();
        end

        // Bounce: 2 high, 1 low, 2 high, then low; nothing may be captured.
        s0 = seen;
        @(negedge clock); confirm_btn = 1'b1; guess_sw = 16'h3456;
        @(negedge clock);
        @(negedge clock); confirm_btn = 1'b0;
        @(negedge clock); confirm_btn = 1'b1;
        @(negedge clock);
        @(negedge clock); confirm_btn = 1'b0;
        repeat (20) @(negedge clock);
        chk("bounce_no_output", 32'(seen), 32'(s0));
        chk("bounce_valid", 32'(guess_valid), 32'd0);

        // Button held through HOLD and accept: no second capture.
        s0 = seen;
        start_press(16'h1234, 1'b1, 2'b00);
        wait_output(s0);
        finish_press(16'h1234, 1'b1, 2'b00, 0);
        s0 = seen;
        guess_sw = 16'h5678;
        repeat (10) @(negedge clock);
        chk("held_no_recapture", 32'(seen), 32'(s0));
        confirm_btn = 1'b0;
        repeat (2) @(negedge clock);
        confirm_btn = 1'b1;
        repeat (10) @(negedge clock);
        chk("short_release_no_recapture", 32'(seen), 32'(s0));
        chk("short_release_guess", 32'(guess), 32'h1234);
        release_btn();
        s0 = seen;
        start_press(16'h5678, 1'b1, 2'b00);
        wait_output(s0);
        finish_press(16'h5678, 1'b1, 2'b00, 0);
        release_btn();

        // Reset in HOLD with the button held through and after reset.
        s0 = seen;
        start_press(16'h9876, 1'b1, 2'b00);
        wait_output(s0);
        @(negedge clock);
        chk("pre_reset_valid", 32'(guess_valid), 32'd1);
        reset = 1'b1;
        @(negedge clock);
        chk("reset_hold_valid", 32'(guess_valid), 32'd0);
        chk("reset_hold_guess", 32'(guess), 32'd0);
        @(negedge clock);
        reset = 1'b0;
        s0 = seen;
        repeat (20) @(negedge clock);
        chk("held_after_reset_no_capture", 32'(seen), 32'(s0));
        chk("held_after_reset_valid", 32'(guess_valid), 32'd0);
        release_btn();
        s0 = seen;
        start_press(16'h0123, 1'b1, 2'b00);
        wait_output(s0);
        finish_press(16'h0123, 1'b1, 2'b00, 3);
        release_btn();

        chk("scoreboard_empty", 32'(sb.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, compared=%0d", compared);
        $fatal(1, "watchdog");
    end

endmodule
